// File: rtl/qerv_op_ser_if.sv
// qerv_op_ser_if: parallel operand handshake in, W-bit serial beat stream out.
// master = operand source / ALU side, slave = serializer.
interface qerv_op_ser_if #(
    parameter int W = 4
);
    logic         i_valid;
    logic         o_ready;
    logic [31:0]  i_rs1;
    logic [31:0]  i_op_b;
    logic         i_hold;
    logic         o_en;
    logic         o_cnt0;
    logic         o_last;
    logic [W-1:0] o_rs1;
    logic [W-1:0] o_op_b;

    modport master (
        output i_valid, i_rs1, i_op_b, i_hold,
        input  o_ready, o_en, o_cnt0, o_last, o_rs1, o_op_b
    );

    modport slave (
        input  i_valid, i_rs1, i_op_b, i_hold,
        output o_ready, o_en, o_cnt0, o_last, o_rs1, o_op_b
    );
endinterface

// File: rtl/qerv_op_ser.sv
// qerv_op_ser: 32-bit rs1/op_b to LSB-first W-bit beats for the serial ALU.
// Optional zero-bubble reload on the last beat: QERV_OP_SER_PREFETCH_EN.
module qerv_op_ser #(
    parameter int W = 4
) (
    input  logic          clk,
    input  logic          i_rst_n,
    qerv_op_ser_if.slave  bus
);
    localparam int N  = 32 / W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (W != 1 && W != 2 && W != 4 && W != 8) begin : g_bad_w
            $error("qerv_op_ser: W must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   sr_rs1;
    logic [31:0]   sr_op_b;

    logic en;
    logic last_beat;
    logic accept;

    assign en        = (state == RUN) & ~bus.i_hold;
    assign last_beat = en & (cnt == CW'(N - 1));

`ifdef QERV_OP_SER_PREFETCH_EN
    // Reload during the final beat so the next word follows with no bubble.
    assign bus.o_ready = (state == IDLE) | last_beat;
`else
    assign bus.o_ready = (state == IDLE);
`endif

    assign accept = bus.i_valid & bus.o_ready;

    assign bus.o_en   = en;
    assign bus.o_cnt0 = en & (cnt == '0);
    assign bus.o_last = last_beat;
    assign bus.o_rs1  = sr_rs1[W-1:0];
    assign bus.o_op_b = sr_op_b[W-1:0];

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            sr_rs1  <= '0;
            sr_op_b <= '0;
        end else if (accept) begin
            state   <= RUN;
            cnt     <= '0;
            sr_rs1  <= bus.i_rs1;
            sr_op_b <= bus.i_op_b;
        end else if (en) begin
            sr_rs1  <= {{W{1'b0}}, sr_rs1[31:W]};
            sr_op_b <= {{W{1'b0}}, sr_op_b[31:W]};
            if (last_beat) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_qerv_op_ser.sv
// tb_qerv_op_ser: directed and randomized checks of qerv_op_ser at W=4 and W=1.
// Randomized phase compares against a beat-queue reference model.
module tb_qerv_op_ser;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    qerv_op_ser_if #(.W(4)) b4 ();
    qerv_op_ser_if #(.W(1)) b1 ();

    qerv_op_ser #(.W(4)) u4 (.clk(clk), .i_rst_n(rst_n), .bus(b4.slave));
    qerv_op_ser #(.W(1)) u1 (.clk(clk), .i_rst_n(rst_n), .bus(b1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef QERV_OP_SER_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] b;
        logic       c0;
        logic       l;
    } beat_t;

    task automatic accept4(input logic [31:0] r, input logic [31:0] b);
        b4.i_valid = 1'b1;
        b4.i_rs1   = r;
        b4.i_op_b  = b;
        @(posedge clk);
        #1;
        b4.i_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({b4.o_en, b4.o_cnt0, b4.o_last, b4.o_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_flags4 got=%b exp=0001",
                     {b4.o_en, b4.o_cnt0, b4.o_last, b4.o_ready});
        end
        checks++;
        if ({b4.o_rs1, b4.o_op_b} !== 8'h00) begin
            failures++;
            $display("FAIL reset_beats4 got=%h exp=00", {b4.o_rs1, b4.o_op_b});
        end
        checks++;
        if ({b1.o_en, b1.o_cnt0, b1.o_last, b1.o_ready, b1.o_rs1, b1.o_op_b} !== 6'b000100) begin
            failures++;
            $display("FAIL reset_w1 got=%b exp=000100",
                     {b1.o_en, b1.o_cnt0, b1.o_last, b1.o_ready, b1.o_rs1, b1.o_op_b});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [31:0] r;
        logic [31:0] b;
        r = 32'h87654321;
        b = 32'h0FEDCBA9;
        accept4(r, b);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (b4.o_en !== 1'b1 || b4.o_rs1 !== r[4*k +: 4] || b4.o_op_b !== b[4*k +: 4]) begin
                failures++;
                $display("FAIL basic_beat k=%0d en=%b rs1=%h opb=%h exp rs1=%h opb=%h",
                         k, b4.o_en, b4.o_rs1, b4.o_op_b, r[4*k +: 4], b[4*k +: 4]);
            end
            checks++;
            if (b4.o_cnt0 !== (k == 0) || b4.o_last !== (k == 7)
                || b4.o_ready !== (PF && k == 7)) begin
                failures++;
                $display("FAIL basic_frame k=%0d cnt0=%b last=%b rdy=%b", k,
                         b4.o_cnt0, b4.o_last, b4.o_ready);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if (b4.o_ready !== 1'b1 || b4.o_en !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle rdy=%b en=%b exp rdy=1 en=0", b4.o_ready, b4.o_en);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_hold();
        int nb;
        int cyc;
        logic [31:0] r;
        r  = 32'h87654321;
        nb = 0;
        cyc = 0;
        accept4(r, 32'h0FEDCBA9);
        while (nb < 8 && cyc < 20) begin
            b4.i_hold = (nb == 3 && cyc < 6) ? 1'b1 : 1'b0;
            @(negedge clk);
            cyc++;
            if (b4.i_hold) begin
                checks++;
                if ({b4.o_en, b4.o_cnt0, b4.o_last, b4.o_ready} !== 4'b0000
                    || b4.o_rs1 !== 4'h4) begin
                    failures++;
                    $display("FAIL hold_frozen cyc=%0d flags=%b rs1=%h exp 0000/4", cyc,
                             {b4.o_en, b4.o_cnt0, b4.o_last, b4.o_ready}, b4.o_rs1);
                end
            end else begin
                checks++;
                if (b4.o_en !== 1'b1 || b4.o_rs1 !== r[4*nb +: 4] || b4.o_last !== (nb == 7)) begin
                    failures++;
                    $display("FAIL hold_beat nb=%0d en=%b rs1=%h last=%b exp rs1=%h",
                             nb, b4.o_en, b4.o_rs1, b4.o_last, r[4*nb +: 4]);
                end
                nb++;
            end
            @(posedge clk);
            #1;
        end
        b4.i_hold = 1'b0;
        checks++;
        if (cyc !== 11) begin
            failures++;
            $display("FAIL hold_span got=%0d exp=11", cyc);
        end
    endtask

    task automatic test_w1();
        logic [31:0] b;
        b = $urandom;
        b1.i_valid = 1'b1;
        b1.i_rs1   = 32'h80000001;
        b1.i_op_b  = b;
        @(posedge clk);
        #1;
        b1.i_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            checks++;
            if (b1.o_en !== 1'b1 || b1.o_rs1 !== ((k == 0 || k == 31) ? 1'b1 : 1'b0)
                || b1.o_op_b !== b[k] || b1.o_last !== (k == 31) || b1.o_cnt0 !== (k == 0)) begin
                failures++;
                $display("FAIL w1_beat k=%0d en=%b rs1=%b opb=%b last=%b cnt0=%b exp opb=%b",
                         k, b1.o_en, b1.o_rs1, b1.o_op_b, b1.o_last, b1.o_cnt0, b[k]);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if (b1.o_en !== 1'b0 || b1.o_ready !== 1'b1) begin
            failures++;
            $display("FAIL w1_idle en=%b rdy=%b exp en=0 rdy=1", b1.o_en, b1.o_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] c;
        accept4(32'h87654321, 32'h0FEDCBA9);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (b4.o_en !== 1'b0 || b4.o_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_async en=%b rdy=%b exp en=0 rdy=1", b4.o_en, b4.o_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checks++;
            if (b4.o_en !== 1'b0 || b4.o_ready !== 1'b1) begin
                failures++;
                $display("FAIL rstmid_quiet k=%0d en=%b rdy=%b", k, b4.o_en, b4.o_ready);
            end
        end
        @(posedge clk);
        #1;
        c = $urandom;
        accept4(c, ~c);
        @(negedge clk);
        checks++;
        if (b4.o_en !== 1'b1 || b4.o_cnt0 !== 1'b1 || b4.o_rs1 !== c[3:0]) begin
            failures++;
            $display("FAIL rstmid_new en=%b cnt0=%b rs1=%h exp 1/1/%h",
                     b4.o_en, b4.o_cnt0, b4.o_rs1, c[3:0]);
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wa;
        logic [31:0] wb;
        bit          acc_now;
        bit          exp_en;
        int          bstart;
        int          idx;
        logic [3:0]  exp_r;
        wa = $urandom;
        wb = $urandom;
        bstart = PF ? 8 : 9;
        b4.i_valid = 1'b1;
        b4.i_rs1   = wa;
        b4.i_op_b  = 32'h0;
        @(posedge clk);
        #1;
        b4.i_rs1 = wb;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            acc_now = b4.i_valid & b4.o_ready;
            exp_en  = (c < 8) || (c >= bstart && c < bstart + 8);
            checks++;
            if (b4.o_en !== exp_en || b4.o_cnt0 !== (c == 0 || c == bstart)
                || b4.o_last !== (c == 7 || c == bstart + 7)) begin
                failures++;
                $display("FAIL b2b_frame c=%0d en=%b cnt0=%b last=%b exp en=%b",
                         c, b4.o_en, b4.o_cnt0, b4.o_last, exp_en);
            end
            if (exp_en) begin
                idx   = (c < 8) ? c : c - bstart;
                exp_r = (c < 8) ? wa[4*idx +: 4] : wb[4*idx +: 4];
                checks++;
                if (b4.o_rs1 !== exp_r) begin
                    failures++;
                    $display("FAIL b2b_data c=%0d got=%h exp=%h", c, b4.o_rs1, exp_r);
                end
            end
            @(posedge clk);
            #1;
            if (acc_now) b4.i_valid = 1'b0;
        end
        b4.i_valid = 1'b0;
    endtask

`ifdef QERV_OP_SER_PREFETCH_EN
    task automatic test_prefetch_hold();
        logic [31:0] wb;
        wb = $urandom;
        accept4(32'h87654321, 32'h0);
        b4.i_valid = 1'b1;
        b4.i_rs1   = wb;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
        end
        b4.i_hold = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (b4.o_ready !== 1'b0 || b4.o_en !== 1'b0 || b4.o_rs1 !== 4'h8) begin
                failures++;
                $display("FAIL pfhold_block rdy=%b en=%b rs1=%h exp 0/0/8",
                         b4.o_ready, b4.o_en, b4.o_rs1);
            end
            @(posedge clk);
            #1;
        end
        b4.i_hold = 1'b0;
        @(negedge clk);
        checks++;
        if (b4.o_ready !== 1'b1 || b4.o_last !== 1'b1) begin
            failures++;
            $display("FAIL pfhold_release rdy=%b last=%b exp 1/1", b4.o_ready, b4.o_last);
        end
        @(posedge clk);
        #1;
        b4.i_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (b4.o_cnt0 !== 1'b1 || b4.o_rs1 !== wb[3:0]) begin
            failures++;
            $display("FAIL pfhold_next cnt0=%b rs1=%h exp 1/%h", b4.o_cnt0, b4.o_rs1, wb[3:0]);
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
        end
    endtask
`endif

    task automatic test_random();
        beat_t q[$];
        beat_t t;
        bit run, e_en, e_c0, e_l, e_rdy, acc;
        b4.i_valid = 1'b0;
        b4.i_hold  = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (c < 360) begin
                if (!b4.i_valid) begin
                    b4.i_valid = ($urandom_range(0, 1) == 1);
                    b4.i_rs1   = $urandom;
                    b4.i_op_b  = $urandom;
                end
                b4.i_hold = ($urandom_range(0, 3) == 0);
            end else begin
                b4.i_valid = 1'b0;
                b4.i_hold  = 1'b0;
            end
            @(negedge clk);
            run   = (q.size() > 0);
            e_en  = run && !b4.i_hold;
            e_c0  = e_en && q[0].c0;
            e_l   = e_en && q[0].l;
            e_rdy = !run || (PF && e_l);
            checks++;
            if ({b4.o_en, b4.o_cnt0, b4.o_last, b4.o_ready} !== {e_en, e_c0, e_l, e_rdy}) begin
                failures++;
                $display("FAIL rand_frame c=%0d got=%b exp=%b", c,
                         {b4.o_en, b4.o_cnt0, b4.o_last, b4.o_ready}, {e_en, e_c0, e_l, e_rdy});
            end
            if (run) begin
                checks++;
                if (b4.o_rs1 !== q[0].r || b4.o_op_b !== q[0].b) begin
                    failures++;
                    $display("FAIL rand_data c=%0d got=%h/%h exp=%h/%h", c,
                             b4.o_rs1, b4.o_op_b, q[0].r, q[0].b);
                end
            end
            @(posedge clk);
            acc = b4.i_valid && e_rdy;
            if (e_en) void'(q.pop_front());
            if (acc) begin
                for (int k = 0; k < 8; k++) begin
                    t.r  = b4.i_rs1[4*k +: 4];
                    t.b  = b4.i_op_b[4*k +: 4];
                    t.c0 = (k == 0);
                    t.l  = (k == 7);
                    q.push_back(t);
                end
            end
            #1;
            if (acc) b4.i_valid = 1'b0;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL rand_drain left=%0d exp=0", q.size());
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        b4.i_valid = 1'b0;
        b4.i_hold  = 1'b0;
        b4.i_rs1   = '0;
        b4.i_op_b  = '0;
        b1.i_valid = 1'b0;
        b1.i_hold  = 1'b0;
        b1.i_rs1   = '0;
        b1.i_op_b  = '0;
        test_reset();
        test_basic();
        test_hold();
        test_w1();
        test_reset_mid();
        test_back_to_back();
`ifdef QERV_OP_SER_PREFETCH_EN
        test_prefetch_hold();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
